peripheral_msi_arbiter_weighted: RTL and testbench
==================================================

Name: peripheral_msi_arbiter_weighted

Overview:
- Parametrised successor to the MSI round-robin bus arbiter.
- Adds a per-port grant quantum (a weight, in cycles), forced rotation on quantum expiry, and per-port lock for atomic bursts.
- Sits between the Wishbone masters and the shared slave mux; `selection` drives the mux and `grant` drives the master cyc/ack gating.

Parameters:
- NUM_PORTS, 6, number of requesting masters (2..32).
- WEIGHT_WIDTH, 4, bits per port quantum; quantum 0 = unlimited (hold while requesting).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- request  input  NUM_PORTS  per-port bus request, level.
- lock  input  NUM_PORTS  per-port lock; suppresses quantum expiry while the owner holds it.
- weight  input  NUM_PORTS*WEIGHT_WIDTH  packed quanta; port i is at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; quasi-static.
- grant  output  NUM_PORTS  registered one-hot grant (token & request).
- selection  output  $clog2(NUM_PORTS)  registered index of the granted port; 0 when none.
- active  output  1  registered OR of grant.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- State: one-hot token (owner), plus tenure counter cnt[WEIGHT_WIDTH-1:0].
- Reset values: token=1 (port 0), cnt=0, grant=0, selection=0, active=0.
- Outputs, every cycle: grant<=token&request; selection<=index(token&request); active<=|(token&request).
- Latency: 1 cycle from token/request to the outputs.
- Wquantum: weight of the current owner.
- own: token&request nonzero.
- others: any request outside the token.
- Case A, !own: token moves to the first requester searching owner+1, owner+2, ... wrapping. If no port requests, token holds. cnt<=0.
- Case B, own, and expiry condition holds: token moves to the first requester searching owner+1 .. owner+NUM_PORTS-1, excluding the owner. cnt<=0.
  - Expiry condition: Wquantum!=0 && cnt+1>=Wquantum && !lock[owner] && others.
- Case C, own, otherwise: token holds. cnt<=cnt+1, saturating at all-ones.
- Consequence: under contention, an unlocked owner shows exactly Wquantum consecutive grant cycles, then the next requester in rotation order is granted. There is no idle gap between tenures.
- Lock behaviour:
  - lock is only evaluated for the current owner.
  - lock on a non-owner has no effect.
  - Deasserting lock while cnt>=Wquantum-1 with others pending forces rotation that same cycle (Case B).
- Weight sampling: weight is sampled combinationally each cycle. Software changes weight only while the bus is idle; mid-tenure changes take effect on the next comparison.
- Single requester: never rotates away; the quantum is ignored (others=0).
- Reset mid-tenure: token returns to port 0, cnt clears, and the outputs clear on the following edge.
- Request drop: if the owner drops request in the same cycle its quantum expires, Case A applies (identical target).

Optional Feature:
- Macro: ARBITER_STATS_EN.
- Enabled: adds output switch_count [15:0].
  - Increments on every token change in Case A or Case B when the target differs from the owner.
  - Saturates at 16'hFFFF; reset to 0.
- Disabled: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package peripheral_msi_arbiter_pkg:
  - ff1 (lowest-set index) function.
  - Parametrised rotate helper.
  - STATS_WIDTH=16 constant.
- Sub-module peripheral_msi_arbiter_rr_pick, combinational:
  - Inputs: token, request, an exclude_owner flag.
  - Outputs: next one-hot token and a found flag.
  - Implementation: doubled-vector rotate search.
- The top level holds token, cnt, the output registers and the stats counter.

Test Plan:
- Quantum expiry: reset; weight all 2; request=6'b000011 held → grant 000001 for 2 cycles, then 000010 for 2, alternating; active stays 1; selection toggles 0/1.
- Unlimited quantum: weight port0=0, request=000101 → grant stays 000001 indefinitely. Drop request[0] → next cycle token moves to port 2; one cycle later grant=000100, selection=2.
- Lock: weight=1, request=000011, lock[0]=1 for 5 cycles → port 0 granted 5+ cycles. Release lock → rotation to port 1 in the next cycle.
- Wrap-around: owner port 5, request=100001, weight=1 → grant alternates 100000/000001; selection 5/0.
- Idle and reset: request=0 → grant=0, active=0, token holds. Assert rst mid-burst on port 3 → all outputs 0 next edge, token=port 0.
- With ARBITER_STATS_EN: the quantum-expiry scenario for 8 tenures → switch_count=7 (first tenure needs no switch).

Source files
------------

// File: rtl/peripheral_msi_arbiter_pkg.sv
// Shared helpers for the weighted MSI bus arbiter: lowest-set search, bounded rotate and
// the width of the optional switch statistics counter.
package peripheral_msi_arbiter_pkg;

    localparam int unsigned STATS_WIDTH = 16;
    localparam int unsigned MAX_PORTS   = 32;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [4:0] ff1(input logic [MAX_PORTS-1:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    // Rotate the low `width` bits of vec right by amt (amt <= width) using a doubled vector.
    function automatic logic [MAX_PORTS-1:0] rotate_right(input logic [MAX_PORTS-1:0] vec,
                                                          input int unsigned width,
                                                          input int unsigned amt);
        logic [2*MAX_PORTS-1:0] dbl;
        logic [MAX_PORTS-1:0]   mask;
        logic [MAX_PORTS-1:0]   masked;
        mask   = (width >= MAX_PORTS) ? '1 : ((MAX_PORTS'(1) << width) - MAX_PORTS'(1));
        masked = vec & mask;
        dbl    = ({{MAX_PORTS{1'b0}}, masked} << width) | {{MAX_PORTS{1'b0}}, masked};
        dbl    = dbl >> amt;
        return dbl[MAX_PORTS-1:0] & mask;
    endfunction

endpackage

// File: rtl/peripheral_msi_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after the current token owner,
// optionally skipping the owner itself.
module peripheral_msi_arbiter_rr_pick
    import peripheral_msi_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 6
) (
    input  logic [NUM_PORTS-1:0] token,
    input  logic [NUM_PORTS-1:0] request,
    input  logic                 exclude_owner,
    output logic [NUM_PORTS-1:0] next_token,
    output logic                 found
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [MAX_PORTS-1:0] token_ext;
    logic [MAX_PORTS-1:0] request_ext;
    logic [MAX_PORTS-1:0] window;
    logic [4:0]           owner;
    logic [4:0]           offset;
    int unsigned          target;

    always_comb begin
        token_ext                   = '0;
        token_ext[NUM_PORTS-1:0]    = token;
        request_ext                 = '0;
        request_ext[NUM_PORTS-1:0]  = request;
        owner                       = ff1(token_ext);
        // Window bit j is port owner+1+j; the top bit wraps back onto the owner itself.
        window = rotate_right(request_ext, NUM_PORTS, 32'(owner) + 32'd1);
        if (exclude_owner) begin
            window[NUM_PORTS-1] = 1'b0;
        end
        found  = |window;
        offset = ff1(window);
        target = 32'(owner) + 32'(offset) + 32'd1;
        if (target >= NUM_PORTS) begin
            target = target - NUM_PORTS;
        end
        next_token = token;
        if (found) begin
            next_token                     = '0;
            next_token[target[IDX_W-1:0]]  = 1'b1;
        end
    end

endmodule

// File: rtl/peripheral_msi_arbiter_weighted.sv
// Weighted round-robin MSI bus arbiter with per-port quantum and lock.
// Optional switch statistics counter enabled by defining ARBITER_STATS_EN.
module peripheral_msi_arbiter_weighted
    import peripheral_msi_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 6,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              request,
    input  logic [NUM_PORTS-1:0]              lock,
    input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] weight,
    output logic [NUM_PORTS-1:0]              grant,
    output logic [$clog2(NUM_PORTS)-1:0]      selection,
    output logic                              active
`ifdef ARBITER_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0]            switch_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]    token_q, token_d;
    logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]        selection_q, selection_d;
    logic                    active_q;

    logic [WEIGHT_WIDTH-1:0] quantum;
    logic                    own;
    logic                    others;
    logic                    owner_locked;
    logic                    expire;
    logic [NUM_PORTS-1:0]    pick_token;
    logic                    pick_found;
    logic [MAX_PORTS-1:0]    grant_ext;

    peripheral_msi_arbiter_rr_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_pick (
        .token        (token_q),
        .request      (request),
        .exclude_owner(own),
        .next_token   (pick_token),
        .found        (pick_found)
    );

    always_comb begin
        quantum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (token_q[i]) begin
                quantum = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        own          = |(token_q & request);
        others       = |(request & ~token_q);
        owner_locked = |(token_q & lock);
        // Compare one bit wider so cnt+1 cannot wrap at saturation.
        expire = own && (quantum != '0) && !owner_locked && others &&
                 (((WEIGHT_WIDTH+1)'(cnt_q) + (WEIGHT_WIDTH+1)'(1)) >=
                  (WEIGHT_WIDTH+1)'(quantum));

        token_d = token_q;
        cnt_d   = '0;
        if (!own) begin
            if (pick_found) begin
                token_d = pick_token;
            end
        end else if (expire) begin
            token_d = pick_token;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + WEIGHT_WIDTH'(1);
        end

        grant_d                  = token_q & request;
        grant_ext                = '0;
        grant_ext[NUM_PORTS-1:0] = grant_d;
        selection_d              = IDX_W'(ff1(grant_ext));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            token_q     <= NUM_PORTS'(1);
            cnt_q       <= '0;
            grant_q     <= '0;
            selection_q <= '0;
            active_q    <= 1'b0;
        end else begin
            token_q     <= token_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            selection_q <= selection_d;
            active_q    <= |grant_d;
        end
    end

    assign grant     = grant_q;
    assign selection = selection_q;
    assign active    = active_q;

`ifdef ARBITER_STATS_EN
    logic [STATS_WIDTH-1:0] switch_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            switch_count_q <= '0;
        end else if ((token_d != token_q) && (switch_count_q != '1)) begin
            switch_count_q <= switch_count_q + STATS_WIDTH'(1);
        end
    end

    assign switch_count = switch_count_q;
`endif

endmodule

// File: tb/tb_peripheral_msi_arbiter_weighted.sv
// Self-checking bench for peripheral_msi_arbiter_weighted: directed scenarios with literal
// expectations plus randomized traffic against a behavioural owner/tenure model.
module tb_peripheral_msi_arbiter_weighted;

    localparam int N  = 6;
    localparam int WW = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  request = '0;
    logic [N-1:0]  lock = '0;
    logic [N*WW-1:0] weight = '0;
    logic [N-1:0]  grant;
    logic [IW-1:0] selection;
    logic          active;
`ifdef ARBITER_STATS_EN
    logic [15:0]   switch_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    peripheral_msi_arbiter_weighted #(
        .NUM_PORTS   (N),
        .WEIGHT_WIDTH(WW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .request  (request),
        .lock     (lock),
        .weight   (weight),
        .grant    (grant),
        .selection(selection),
        .active   (active)
`ifdef ARBITER_STATS_EN
        ,
        .switch_count(switch_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: owner as an integer index, tenure as an integer count.
    int           m_owner = 0;
    int           m_cnt = 0;
    logic [N-1:0] exp_grant = '0;
    int           exp_sel = 0;
    logic         exp_active = 1'b0;
    int           exp_sw = 0;

    always @(posedge clk) begin : model
        int  w, nxt, ncnt;
        bit  own, others, expire, found;
        if (rst) begin
            m_owner    <= 0;
            m_cnt      <= 0;
            exp_grant  <= '0;
            exp_sel    <= 0;
            exp_active <= 1'b0;
            exp_sw     <= 0;
        end else begin
            own    = request[m_owner];
            others = (request & ~(N'(1) << m_owner)) != '0;
            w      = int'(weight[m_owner*WW +: WW]);
            exp_grant  <= own ? (N'(1) << m_owner) : '0;
            exp_sel    <= own ? m_owner : 0;
            exp_active <= own;
            expire = own && (w != 0) && (m_cnt + 1 >= w) && !lock[m_owner] && others;
            nxt  = m_owner;
            ncnt = 0;
            if (!own || expire) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && request[(m_owner + k) % N] && !(own && k == N)) begin
                        nxt   = (m_owner + k) % N;
                        found = 1;
                    end
                end
            end else begin
                ncnt = (m_cnt + 1 > (1 << WW) - 1) ? (1 << WW) - 1 : m_cnt + 1;
            end
            if (nxt != m_owner && exp_sw < 65535) exp_sw <= exp_sw + 1;
            m_owner <= nxt;
            m_cnt   <= ncnt;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_grant", 32'(grant), 32'(exp_grant));
            chk("model_selection", 32'(selection), 32'(exp_sel));
            chk("model_active", 32'(active), 32'(exp_active));
`ifdef ARBITER_STATS_EN
            chk("model_switch_count", 32'(switch_count), 32'(exp_sw));
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_all_weights(input int w);
        for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'(w);
    endtask

    // Leaves the bench at a negedge with rst just released.
    task automatic do_reset();
        rst     = 1'b1;
        request = '0;
        lock    = '0;
        repeat (2) cyc();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_selection", 32'(selection), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
`ifdef ARBITER_STATS_EN
        chk("reset_switch_count", 32'(switch_count), 32'd0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        set_all_weights(2);
        @(negedge clk);
        cmp_en = 1'b1;
        do_reset();

        // Quantum expiry: weight 2, ports 0 and 1 alternate every two cycles.
        request = 6'b000011;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("quantum_grant", 32'(grant), (((k - 1) / 2) % 2 == 0) ? 32'h01 : 32'h02);
            chk("quantum_active", 32'(active), 32'd1);
`ifdef ARBITER_STATS_EN
            if (k == 15) chk("stats_eight_tenures", 32'(switch_count), 32'd7);
`endif
        end

        // Unlimited quantum on port 0.
        do_reset();
        set_all_weights(1);
        weight[0 +: WW] = '0;
        request = 6'b000101;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("unlimited_grant", 32'(grant), 32'h01);
        end
        request = 6'b000100;
        cyc();
        chk("drop_gap_grant", 32'(grant), 32'h00);
        cyc();
        chk("drop_new_grant", 32'(grant), 32'h04);
        chk("drop_new_selection", 32'(selection), 32'd2);

        // Idle: outputs clear but the token stays on port 2.
        request = '0;
        repeat (2) cyc();
        chk("idle_grant", 32'(grant), 32'h00);
        chk("idle_active", 32'(active), 32'd0);
        request = 6'b000100;
        cyc();
        chk("idle_hold_grant", 32'(grant), 32'h04);

        // Lock holds port 0 past its quantum; release rotates at once.
        do_reset();
        set_all_weights(1);
        request = 6'b000011;
        lock    = 6'b000001;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("lock_grant", 32'(grant), 32'h01);
        end
        lock = '0;
        cyc();
        chk("unlock_last_grant", 32'(grant), 32'h01);
        cyc();
        chk("unlock_rotate_grant", 32'(grant), 32'h02);

        // Wrap-around between port 5 and port 0.
        do_reset();
        request = 6'b100000;
        repeat (2) cyc();
        chk("wrap_start_grant", 32'(grant), 32'h20);
        request = 6'b100001;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk("wrap_selection", 32'(selection), (k % 2 == 1) ? 32'd5 : 32'd0);
            chk("wrap_grant", 32'(grant), (k % 2 == 1) ? 32'h20 : 32'h01);
        end

        // Reset mid-burst on port 3.
        do_reset();
        set_all_weights(3);
        request = 6'b001000;
        repeat (3) cyc();
        chk("burst_grant", 32'(grant), 32'h08);
        rst = 1'b1;
        cyc();
        chk("midreset_grant", 32'(grant), 32'h00);
        chk("midreset_selection", 32'(selection), 32'd0);
        chk("midreset_active", 32'(active), 32'd0);
        rst = 1'b0;
        request = 6'b001001;
        cyc();
        chk("post_reset_owner", 32'(grant), 32'h01);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) request = N'($urandom) & N'($urandom | $urandom);
            if ($urandom_range(0, 7) == 0) lock = N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < N; i++) weight[i*WW +: WW] = WW'($urandom_range(0, 5));
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
